counter_display_driver: RTL and testbench

// Consumes the N-bit binary output of the up/down counter stage and shows it on
// the board's multiplexed 8-digit, active-low 7-segment display. Free-running

---
 rtl/counter_display_driver_pkg.sv | 28 ++
 rtl/counter_display_driver_if.sv | 25 ++
 rtl/counter_display_driver_seg7_decoder.sv | 32 +++
 rtl/counter_display_driver.sv | 176 +++++++++++++++++
 tb/tb_counter_display_driver.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_display_driver_pkg.sv
// Shared types and constants for the counter display driver: conversion FSM
// states, segment patterns and the double-dabble helpers.
package counter_display_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Elaboration-time 10**e; only meaningful while the result fits 64 bits.
    function automatic longint unsigned pow10(input int e);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < e; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/counter_display_driver_if.sv
// Value/mode inputs and display outputs of the counter display driver.
// The counter side is the master, the display driver is the slave.
interface counter_display_driver_if #(
    parameter int N      = 32,
    parameter int DIGITS = 8
);
    logic [N-1:0]      value;
    logic              hex_mode;
    logic              blank_zeros;
    logic              busy;
    logic              overflow;
    logic [6:0]        segments;
    logic              dp;
    logic [DIGITS-1:0] anodes;

    modport master (
        output value, hex_mode, blank_zeros,
        input  busy, overflow, segments, dp, anodes
    );

    modport slave (
        input  value, hex_mode, blank_zeros,
        output busy, overflow, segments, dp, anodes
    );
endinterface

// File: rtl/counter_display_driver_seg7_decoder.sv
// Combinational hex digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decoder
    import counter_display_driver_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/counter_display_driver.sv
// Binary counter value -> multiplexed active-low 7-segment display: free-running
// double-dabble (or hex pass-through), atomic display register, digit scan.
module counter_display_driver
    import counter_display_driver_pkg::*;
#(
    parameter int N        = 32,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100_000
)
(
    input  logic                   clock,
    input  logic                   reset,
    counter_display_driver_if.slave dif
);

    localparam int DW = 4 * DIGITS;
    localparam int WW = (N > 64) ? N : 64;
    localparam int CW = $clog2(N + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Decimal overflow is only possible when 10**DIGITS fits in N bits.
    localparam bit DEC_REACH = (DIGITS < 20) &&
                               ((N >= 64) || ((pow10(DIGITS) >> N) == 64'd0));
    localparam logic [WW-1:0] DEC_LIMIT = WW'(pow10(DIGITS));

    conv_state_t       state;
    conv_state_t       state_nxt;
    logic              busy_c;

    logic [N-1:0]      shadow_bin;
    logic              shadow_hex;
    logic              shadow_ovf;
    logic [DW-1:0]     bcd;
    logic [DW-1:0]     bcd_adj;
    logic [CW-1:0]     cnt;
    logic [WW-1:0]     val_w;
    logic              dec_ovf;
    logic              hex_ovf;

    logic [DW-1:0]     disp;
    logic              disp_ovf;

    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [DIGITS-1:0] lead_zero;
    logic [3:0]        digit_cur;
    logic [6:0]        seg_dec;
    logic [6:0]        seg_c;
    logic [DIGITS-1:0] anodes_q;
    logic [6:0]        seg_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        unique case (state)
            IDLE:  state_nxt = dif.hex_mode ? LOAD : SHIFT;
            SHIFT: begin
                busy_c = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    state_nxt = LOAD;
                end
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = dabble_adj(bcd[4*i +: 4]);
        end
    end

    assign val_w   = WW'(dif.value);
    assign dec_ovf = DEC_REACH && (val_w >= DEC_LIMIT);
    assign hex_ovf = (val_w >> DW) != '0;

    // ---- conversion datapath: capture / shift / load to display register ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_bin <= '0;
            shadow_hex <= 1'b0;
            shadow_ovf <= 1'b0;
            bcd        <= '0;
            cnt        <= '0;
            disp       <= '0;
            disp_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    shadow_bin <= dif.value;
                    shadow_hex <= dif.hex_mode;
                    shadow_ovf <= dif.hex_mode ? hex_ovf : dec_ovf;
                    bcd        <= '0;
                    cnt        <= '0;
                end
                SHIFT: begin
                    // Carry out of the top BCD digit is dropped by the cast.
                    bcd        <= DW'({bcd_adj, shadow_bin[N-1]});
                    shadow_bin <= shadow_bin << 1;
                    cnt        <= cnt + CW'(1);
                end
                LOAD: begin
                    disp     <= shadow_hex ? DW'(shadow_bin) : bcd;
                    disp_ovf <= shadow_ovf;
                end
                default: ;
            endcase
        end
    end

    // ---- scan timing: prescaler and digit index ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = (disp[DW-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (disp[4*i +: 4] == 4'd0);
        end
    end

    assign digit_cur = disp[4*idx +: 4];

    seg7_decoder u_dec (
        .digit (digit_cur),
        .seg   (seg_dec)
    );

    always_comb begin
        seg_c = seg_dec;
        if (disp_ovf) begin
            seg_c = SEG_DASH;
        end else if (dif.blank_zeros && (idx != '0) && lead_zero[idx]) begin
            seg_c = SEG_OFF;
        end
    end

    // ---- output registers: anodes and segments switch on the same edge ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anodes_q <= '1;
            seg_q    <= SEG_OFF;
        end else begin
            anodes_q <= ~(DIGITS'(1) << idx);
            seg_q    <= seg_c;
        end
    end

    assign dif.busy     = busy_c;
    assign dif.overflow = disp_ovf;
    assign dif.segments = seg_q;
    assign dif.dp       = 1'b1;
    assign dif.anodes   = anodes_q;

endmodule

// File: tb/tb_counter_display_driver.sv
// Scoreboard bench for counter_display_driver: stimulus pushes expected digit
// patterns, a monitor collects one scan round from the pins and compares.
module tb_counter_display_driver;

    typedef struct {
        logic [7:0][6:0] seg;
        logic            ovf;
        logic [7:0]      mask;
        int              id;
    } exp_t;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   chk_id;
    exp_t sb_q[$];

    logic [7:0] seen;
    int         mon_cyc;

    counter_display_driver_if #(.N(32), .DIGITS(8)) dif ();

    counter_display_driver #(.N(32), .DIGITS(8), .SCAN_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .dif   (dif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic exp_t model(input logic [31:0] v, input bit hx, input bit bz);
        exp_t            e;
        int unsigned     d [8];
        longint unsigned p;
        int              top;
        e.ovf  = !hx && (v >= 32'd100_000_000);
        e.mask = 8'hFF;
        e.id   = 0;
        p      = 1;
        for (int i = 0; i < 8; i++) begin
            d[i] = hx ? ((v >> (4 * i)) & 32'hF) : int'((longint'(v) / p) % 10);
            p    = p * 10;
        end
        top = 0;
        for (int i = 0; i < 8; i++) if (d[i] != 0) top = i;
        for (int i = 0; i < 8; i++) begin
            if (e.ovf)               e.seg[i] = 7'b0111111;
            else if (bz && i > top)  e.seg[i] = 7'h7F;
            else                     e.seg[i] = SEG_TAB[d[i]];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int g = 0;
        while (dif.busy !== lvl && g < 200) begin
            @(negedge clock);
            g++;
        end
        if (g >= 200) timeout(name);
    endtask

    task automatic push(input exp_t e);
        chk_id++;
        e.id = chk_id;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int g = 0;
        while (sb_q.size() != 0 && g < 400) begin
            @(negedge clock);
            g++;
        end
        if (g >= 400) begin
            timeout("scoreboard_drain");
            sb_q.delete();
        end
    endtask

    task automatic apply_and_check(input logic [31:0] v, input bit hx, input bit bz);
        dif.value       = v;
        dif.hex_mode    = hx;
        dif.blank_zeros = bz;
        repeat (80) @(negedge clock);
        push(model(v, hx, bz));
        drain();
    endtask

    // Monitor: gathers each masked digit once from the live scan, then the overflow pin.
    always @(negedge clock) begin
        if (reset === 1'b1 && sb_q.size() != 0) begin
            logic [7:0] oh;
            int         k;
            mon_cyc++;
            oh = ~dif.anodes;
            k  = -1;
            for (int j = 0; j < 8; j++) if (oh[j]) k = j;
            total++;
            if ($countones(oh) != 1) begin
                bad++;
                $display("FAIL anode_onehot (chk %0d): anodes=%h required one low bit", sb_q[0].id, dif.anodes);
            end else if (sb_q[0].mask[k] && !seen[k]) begin
                seen[k] = 1'b1;
                total++;
                if (dif.segments !== sb_q[0].seg[k]) begin
                    bad++;
                    $display("FAIL digit%0d (chk %0d): segments=%b required %b",
                             k, sb_q[0].id, dif.segments, sb_q[0].seg[k]);
                end
            end
            if ((seen & sb_q[0].mask) == sb_q[0].mask) begin
                total++;
                if (dif.overflow !== sb_q[0].ovf) begin
                    bad++;
                    $display("FAIL overflow (chk %0d): got %b required %b",
                             sb_q[0].id, dif.overflow, sb_q[0].ovf);
                end
                void'(sb_q.pop_front());
                seen    = '0;
                mon_cyc = 0;
            end else if (mon_cyc > 200) begin
                timeout("monitor_scan");
                void'(sb_q.pop_front());
                seen    = '0;
                mon_cyc = 0;
            end
        end
    end

    initial begin
        int         n;
        int         dwell;
        logic [7:0] cur;
        exp_t       e;
        logic [31:0] rv;

        total   = 0;
        bad     = 0;
        chk_id  = 0;
        seen    = '0;
        mon_cyc = 0;
        reset   = 1'b0;
        dif.value       = 32'd1234;
        dif.hex_mode    = 1'b0;
        dif.blank_zeros = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_anodes",   32'(dif.anodes),   32'hFF);
        check("rst_segments", 32'(dif.segments), 32'h7F);
        check("rst_busy",     32'(dif.busy),     32'h0);
        check("rst_overflow", 32'(dif.overflow), 32'h0);
        check("rst_dp",       32'(dif.dp),       32'h1);
        reset = 1'b1;

        // Decimal 1234: busy length, then displayed digits
        wait_busy(1'b1, "busy_rise");
        n = 0;
        while (dif.busy === 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("busy_cycles", 32'(n), 32'd32);
        apply_and_check(32'd1234, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a conversion
        wait_busy(1'b1, "busy_rise_mid");
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_anodes",   32'(dif.anodes),   32'hFF);
        check("async_segments", 32'(dif.segments), 32'h7F);
        check("async_busy",     32'(dif.busy),     32'h0);
        check("async_overflow", 32'(dif.overflow), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_anodes",   32'(dif.anodes),   32'hFE);
        check("post_rst_segments", 32'(dif.segments), 32'h40);

        // Hex 0xAB with leading-zero blanking, then anode stepping
        apply_and_check(32'h0000_00AB, 1'b1, 1'b1);
        cur = dif.anodes;
        n   = 0;
        while (dif.anodes === cur && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) timeout("anode_sync");
        for (int s = 0; s < 8; s++) begin
            cur   = dif.anodes;
            dwell = 0;
            while (dif.anodes === cur && dwell < 20) begin
                @(negedge clock);
                dwell++;
            end
            check("anode_dwell", 32'(dwell), 32'd4);
            check("anode_step",  32'(dif.anodes), 32'({cur[6:0], cur[7]}));
        end

        // Decimal overflow, zero with blanking
        apply_and_check(32'd100_000_000, 1'b0, 1'b0);
        apply_and_check(32'd0, 1'b0, 1'b1);

        // Value change during SHIFT is ignored until the next capture
        apply_and_check(32'd7, 1'b0, 1'b0);
        wait_busy(1'b1, "chg_busy_rise0");
        wait_busy(1'b0, "chg_busy_fall0");
        dif.value = 32'd5;
        wait_busy(1'b1, "chg_busy_rise1");
        repeat (10) @(negedge clock);
        dif.value = 32'd9;
        wait_busy(1'b0, "chg_busy_fall1");
        repeat (2) @(negedge clock);
        e = model(32'd5, 1'b0, 1'b0);
        e.mask = 8'h01;
        push(e);
        drain();
        repeat (80) @(negedge clock);
        push(model(32'd9, 1'b0, 1'b0));
        drain();

        // Randomized values across modes and ranges
        for (int t = 0; t < 15; t++) begin
            case ($urandom_range(0, 3))
                0:       rv = $urandom_range(0, 999);
                1:       rv = $urandom_range(0, 99_999_999);
                2:       rv = 32'd99_999_990 + $urandom_range(0, 20);
                default: rv = $urandom;
            endcase
            apply_and_check(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
